// File: rtl/match_pkg.sv
// Shared types and constants for the compression matching-stage front end.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int WORD_W         = 32;
  localparam int DEF_DICT_ENTRY = 16;
  localparam int PAGE_BEATS     = 512;

endpackage

// File: rtl/match_stage_sequencer.sv
// Front-end sequencer: flushes the dictionary, then passes page-buffer beats
// through a one-entry output register while framing the block for the encoder.
module match_stage_sequencer
  import match_pkg::*;
#(
  parameter int WIDTH       = 2 * WORD_W,
  parameter int DICT_ENTRY  = DEF_DICT_ENTRY,
  parameter int BLOCK_BEATS = PAGE_BEATS,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_word,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_word,
  output logic             o_dict_wr_en,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_first,
  output logic             o_out_last,
  output logic             o_clear_active,
  output logic [CNT_W-1:0] o_beat_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_short,
  output seq_state_t       o_state
);

  // Handshakes: a beat moves upstream->register when i_in_valid && o_in_ready,
  // and register->encoder when o_out_valid && i_out_ready, both at the rising edge.

  localparam int CLR_CYC = DICT_ENTRY / 2;
  localparam int CLR_W   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BLOCK_BEATS - 1);

  seq_state_t       state_q, state_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  logic in_ready;
  logic accept;
  logic consume;
  logic is_last;

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    v_d      = v_q;
    word_d   = word_q;
    first_d  = first_q;
    last_d   = last_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = CLEAR;
          clr_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          word_d  = '0;
        end
      end
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CLR_LAST) state_d = RUN;
      end
      RUN:     in_ready = !v_q || i_out_ready;
      DRAIN:   ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Only RUN and DRAIN ever hold V=1, so consume is naturally confined there.
    consume = v_q && i_out_ready;
    accept  = i_in_valid && in_ready;
    is_last = accept && ((cnt_q == BEAT_LAST) || i_in_last);

    if (consume) begin
      v_d     = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      if (state_q == DRAIN) state_d = DONE;
    end

    // A fresh accept overrides the consume clear in the same cycle.
    if (accept) begin
      word_d  = i_in_word;
      v_d     = 1'b1;
      first_d = (cnt_q == '0);
      last_d  = is_last;
      cnt_d   = cnt_q + 1'b1;
      if (is_last) begin
        state_d = DRAIN;
        if (cnt_q != BEAT_LAST) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      clr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      v_q     <= 1'b0;
      word_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      v_q     <= v_d;
      word_q  <= word_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign o_in_ready     = in_ready;
  assign o_word         = word_q;
  assign o_dict_wr_en   = (state_q == CLEAR) || consume;
  assign o_out_valid    = v_q;
  assign o_out_first    = first_q;
  assign o_out_last     = last_q;
  assign o_clear_active = (state_q == CLEAR);
  assign o_beat_cnt     = cnt_q;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = (state_q == DONE);
  assign o_err_short    = err_q;
  assign o_state        = state_q;

endmodule
